// File: rtl/dcim_pkg.sv
// Shared constants and helpers for the DCIM accumulate pipeline.
package dcim_pkg;

  localparam int N_ELEM = 32;               // elements per vector
  localparam int ELEM_W = 4;                // bits per weight/activation element
  localparam int N_ROWS = 4;                // weight rows, one per output channel
  localparam int VEC_W  = N_ELEM * ELEM_W;  // 128-bit packed vector
  localparam int BIT_W  = $clog2(ELEM_W);   // width of a plane bit index
  localparam int ACC_W  = 13;               // accumulator width of the DCIM stage

  // Gate one weight nibble with a single activation bit.
  function automatic logic [ELEM_W-1:0] mask_elem(input logic [ELEM_W-1:0] w,
                                                  input logic              a);
    return w & {ELEM_W{a}};
  endfunction

endpackage

// File: rtl/dcim_plane_gate.sv
// One bit-plane product: every weight nibble ANDed with the selected
// activation bit of the same element.
module dcim_plane_gate
  import dcim_pkg::*;
(
  input  logic [VEC_W-1:0] w_row,
  input  logic [VEC_W-1:0] vec,
  input  logic [BIT_W-1:0] bit_idx,
  output logic [VEC_W-1:0] prod
);

  // Mask each weight nibble with bit bit_idx of the matching activation element.
  always_comb begin
    prod = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      prod[k*ELEM_W +: ELEM_W] = mask_elem(w_row[k*ELEM_W +: ELEM_W],
                                           vec[k*ELEM_W + int'(bit_idx)]);
    end
  end

endmodule

// File: rtl/dcim_bitplane_feeder.sv
// Bit-plane feeder: serialises each accepted activation vector MSB first
// into four planes and emits the four per-row plane products on four
// consecutive cycles, so the downstream group-of-4 counter stays aligned.
module dcim_bitplane_feeder
  import dcim_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w_we,
  input  logic [1:0]         w_sel,
  input  logic [VEC_W-1:0]   w_data,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [VEC_W-1:0]   act_data,
  output logic               out_valid,
  output logic [VEC_W-1:0]   out_data1,
  output logic [VEC_W-1:0]   out_data2,
  output logic [VEC_W-1:0]   out_data3,
  output logic [VEC_W-1:0]   out_data4
);

  logic [VEC_W-1:0] weights [N_ROWS];
  logic             busy;
  logic [BIT_W-1:0] phase;
  logic [VEC_W-1:0] act_q;

  logic             accept;
  logic             emit;
  logic [VEC_W-1:0] plane_vec;
  logic [BIT_W-1:0] plane_bit;
  logic [VEC_W-1:0] prod [N_ROWS];

  assign act_ready = rst_n & ~busy;
  assign accept    = act_valid & act_ready;
  assign emit      = accept | busy;

  // Select the plane source: the incoming vector's MSB on accept, else the held copy.
  always_comb begin
    plane_vec = act_q;
    plane_bit = phase;
    if (accept) begin
      plane_vec = act_data;
      plane_bit = 2'd3;
    end else begin
      plane_vec = act_q;
      plane_bit = phase;
    end
  end

  for (genvar r = 0; r < N_ROWS; r++) begin : g_gate
    dcim_plane_gate u_gate (
      .w_row   (weights[r]),
      .vec     (plane_vec),
      .bit_idx (plane_bit),
      .prod    (prod[r])
    );
  end

  // Weight file; a write lands after this edge's emission has sampled the old row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < N_ROWS; r++) begin
        weights[r] <= '0;
      end
    end else if (w_we) begin
      weights[w_sel] <= w_data;
    end
  end

  // Busy/phase sequencing: bit 3 emits on accept, bits 2..0 on the following edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      phase <= 2'd0;
      act_q <= '0;
    end else if (accept) begin
      act_q <= act_data;
      busy  <= 1'b1;
      phase <= 2'd2;
    end else if (busy) begin
      phase <= phase - 2'd1;
      busy  <= (phase != 2'd0);
    end
  end

  // Registered plane products; zero whenever nothing is emitted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data1 <= '0;
      out_data2 <= '0;
      out_data3 <= '0;
      out_data4 <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data1 <= prod[0];
      out_data2 <= prod[1];
      out_data3 <= prod[2];
      out_data4 <= prod[3];
    end else begin
      out_valid <= 1'b0;
      out_data1 <= '0;
      out_data2 <= '0;
      out_data3 <= '0;
      out_data4 <= '0;
    end
  end

endmodule
